// File: rtl/bht_pkg.sv
// Shared types and helpers for the branch history table port scheduler.
//   ctr_t       : 2-bit saturating counter (0 SNT, 1 WNT, 2 WT, 3 ST)
//   state_t     : sweep/run state of the scheduler
//   upd_t       : one buffered resolution (index, outcome, earlier prediction)
//   ctr_inc_sat / ctr_dec_sat : saturating counter steps
package bht_pkg;

    typedef logic [1:0] ctr_t;

    localparam ctr_t CTR_SNT = 2'd0;
    localparam ctr_t CTR_WNT = 2'd1;
    localparam ctr_t CTR_WT  = 2'd2;
    localparam ctr_t CTR_ST  = 2'd3;

    typedef enum logic {ST_INIT, ST_RUN} state_t;

    // The index field is sized for the widest table supported; users
    // zero-extend on push and take the low IDX_W bits on pop.
    localparam int unsigned IDX_W_MAX = 16;

    typedef struct packed {
        logic [IDX_W_MAX-1:0] index;
        logic                 taken;
        logic                 pred;
    } upd_t;

    function automatic ctr_t ctr_inc_sat(input ctr_t c);
        case (c)
            CTR_SNT: return CTR_WNT;
            CTR_WNT: return CTR_WT;
            default: return CTR_ST;
        endcase
    endfunction

    function automatic ctr_t ctr_dec_sat(input ctr_t c);
        case (c)
            CTR_ST:  return CTR_WT;
            CTR_WT:  return CTR_WNT;
            default: return CTR_SNT;
        endcase
    endfunction

endpackage

// File: rtl/bht_upd_fifo.sv
// Resolution FIFO for the BHT port scheduler.
//   clk, rst   : clock, asynchronous active-high reset
//   flush      : synchronous empty (driven by the scheduler's clear)
//   push       : write push_data (ignored when full unless popping too)
//   pop        : remove the head entry (ignored when empty)
//   head       : oldest entry
//   count      : occupancy 0..UPD_DEPTH
//   full/empty : occupancy flags
module bht_upd_fifo
    import bht_pkg::*;
#(
    parameter  int unsigned UPD_DEPTH = 4,
    localparam int unsigned CNT_W     = $clog2(UPD_DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             push,
    input  upd_t             push_data,
    input  logic             pop,
    output upd_t             head,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);

    localparam int unsigned PTR_W = $clog2(UPD_DEPTH);

    upd_t             mem [UPD_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CNT_W'(UPD_DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr];

    // Power-of-two depth: pointers wrap by plain overflow.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/bht_port_scheduler.sv
// Branch history table behind a single access port, shared between
// fetch-side lookups and buffered execute-side resolutions. Runs the
// table-initialisation sweep after reset and after clear.
//   clk, rst          : clock, asynchronous active-high reset
//   clear             : synchronous soft clear, restarts the sweep
//   busy              : sweep in progress
//   lk_valid/ready/index            : lookup request handshake
//   pred_valid/taken/index          : prediction, one cycle after accept
//   up_valid/ready/index/taken/pred : resolution push handshake
// Optional (macro BHT_STATS_EN): stat_lookups, stat_mispred counters.
module bht_port_scheduler
    import bht_pkg::*;
#(
    parameter int unsigned IDX_W     = 6,
    parameter int unsigned UPD_DEPTH = 4,
    parameter ctr_t        INIT_CTR  = CTR_WT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    output logic             busy,
    input  logic             lk_valid,
    output logic             lk_ready,
    input  logic [IDX_W-1:0] lk_index,
    output logic             pred_valid,
    output logic             pred_taken,
    output logic [IDX_W-1:0] pred_index,
    input  logic             up_valid,
    output logic             up_ready,
    input  logic [IDX_W-1:0] up_index,
    input  logic             up_taken,
    input  logic             up_pred
`ifdef BHT_STATS_EN
    ,
    output logic [31:0]      stat_lookups,
    output logic [31:0]      stat_mispred
`endif
);

    localparam int unsigned DEPTH = 1 << IDX_W;
    localparam int unsigned CNT_W = $clog2(UPD_DEPTH) + 1;

    state_t             state;
    state_t             state_nxt;
    logic [IDX_W-1:0]   init_ptr;
    ctr_t               ctr_tbl [DEPTH];

    upd_t               push_data;
    upd_t               head;
    logic [CNT_W-1:0]   count;
    logic               full;
    logic               empty;
    logic               push;
    logic [IDX_W-1:0]   upd_idx;

    logic               init_wr;
    logic               update_grant;
    logic               lookup_go;
    logic               unused_bits;

    assign push_data   = {IDX_W_MAX'(up_index), up_taken, up_pred};
    assign upd_idx     = head.index[IDX_W-1:0];
    assign up_ready    = !rst && !clear && !full;
    assign push        = up_valid && up_ready;
    assign unused_bits = ^{head.pred, head.index, up_pred, count};

    bht_upd_fifo #(
        .UPD_DEPTH (UPD_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .flush     (clear),
        .push      (push),
        .push_data (push_data),
        .pop       (update_grant),
        .head      (head),
        .count     (count),
        .full      (full),
        .empty     (empty)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_INIT;
        else     state <= state_nxt;
    end

    // A full FIFO takes the port outright; otherwise a waiting lookup wins
    // and updates only drain on idle cycles. clear blocks both.
    always_comb begin
        state_nxt    = state;
        busy         = 1'b0;
        lk_ready     = 1'b0;
        init_wr      = 1'b0;
        update_grant = 1'b0;
        lookup_go    = 1'b0;
        case (state)
            ST_INIT: begin
                busy = 1'b1;
                if (!clear) begin
                    init_wr = 1'b1;
                    if (init_ptr == '1) state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                lk_ready     = !clear && !full;
                update_grant = !clear && (full || (!empty && !lk_valid));
                lookup_go    = lk_valid && lk_ready;
            end
            default: state_nxt = ST_INIT;
        endcase
        if (clear) state_nxt = ST_INIT;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            init_ptr   <= '0;
            pred_valid <= 1'b0;
            pred_taken <= 1'b0;
            pred_index <= '0;
        end else begin
            // Wraps back to 0 after the last entry, ready for the next sweep.
            if (clear)        init_ptr <= '0;
            else if (init_wr) init_ptr <= init_ptr + IDX_W'(1);
            pred_valid <= lookup_go;
            if (lookup_go) begin
                pred_taken <= ctr_tbl[lk_index][1];
                pred_index <= lk_index;
            end
        end
    end

    // Single port: sweep write, update read-modify-write and lookup read
    // are mutually exclusive by construction of the grants above.
    always_ff @(posedge clk) begin
        if (init_wr)
            ctr_tbl[init_ptr] <= INIT_CTR;
        else if (update_grant)
            ctr_tbl[upd_idx] <= head.taken ? ctr_inc_sat(ctr_tbl[upd_idx])
                                           : ctr_dec_sat(ctr_tbl[upd_idx]);
    end

`ifdef BHT_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_lookups <= '0;
            stat_mispred <= '0;
        end else if (clear) begin
            stat_lookups <= '0;
            stat_mispred <= '0;
        end else begin
            if (lookup_go)                      stat_lookups <= stat_lookups + 32'd1;
            if (push && (up_pred != up_taken))  stat_mispred <= stat_mispred + 32'd1;
        end
    end
`endif

endmodule
